myip_axi4_slave_mem: RTL and testbench
======================================

MYIP_AXI4_SLAVE_MEM -- requirements
Module: myip_axi4_slave_mem

Interface
REQ-001 SHALL have parameter C_S_AXI_ID_WIDTH, default 1: width of all ID fields.
REQ-002 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32: data width, fixed at 32.
REQ-003 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 8: byte address width, giving 64 words.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- S_AXI_ACLK  in  1  clock
- S_AXI_ARESETN  in  1  asynchronous active-low reset
- S_AXI_AWID/AWADDR/AWLEN/AWSIZE/AWBURST  in  ID/ADDR/8/3/2  write address
- S_AXI_AWVALID in 1; S_AXI_AWREADY out 1  write address handshake
- S_AXI_WDATA/WSTRB/WLAST  in  32/4/1  write data
- S_AXI_WVALID in 1; S_AXI_WREADY out 1  write data handshake
- S_AXI_BID/BRESP  out  ID/2  write response
- S_AXI_BVALID out 1; S_AXI_BREADY in 1  response handshake
- S_AXI_ARID/ARADDR/ARLEN/ARSIZE/ARBURST  in  ID/ADDR/8/3/2  read address
- S_AXI_ARVALID in 1; S_AXI_ARREADY out 1  read address handshake
- S_AXI_RID/RDATA/RRESP/RLAST  out  ID/32/2/1  read data
- S_AXI_RVALID out 1; S_AXI_RREADY in 1  read data handshake
REQ-005 SHALL omit the LOCK/CACHE/PROT/QOS/REGION/USER ports; the block design ties these off at the master.

Function
REQ-006 SHALL store data in a 64x32 register array indexed by address bits [7:2]; addresses wrap modulo 256 bytes.
REQ-007 Write FSM SHALL have three states: W_IDLE (AWREADY=1), W_DATA (WREADY=1), W_RESP (BVALID=1).
REQ-008 W_IDLE SHALL latch AWID, AWADDR, AWLEN and AWBURST on the AW handshake, then move to W_DATA.
REQ-009 W_DATA SHALL update each byte lane with WSTRB=1 on every W handshake.
REQ-010 Beat address handling per burst type:
- INCR: address += 4 per beat.
- FIXED: address held.
- WRAP and reserved types: no array writes, beats still consumed.
REQ-011 W_DATA SHALL move to W_RESP on the handshake with WLAST=1.
REQ-012 BRESP SHALL be SLVERR (2'b10) when any of the following hold, else OKAY (2'b00):
- burst type is WRAP or reserved;
- AWSIZE is not 3'b010;
- WLAST does not coincide with beat count == AWLEN.
REQ-013 BID SHALL equal the latched AWID.
REQ-014 BVALID SHALL hold until BREADY; W_RESP then returns to W_IDLE.
REQ-015 AWREADY SHALL be low outside W_IDLE, so only one write is outstanding.
REQ-016 Read FSM SHALL have two states: R_IDLE (ARREADY=1) and R_DATA (RVALID=1).
REQ-017 Read timing:
- On the AR handshake, RDATA SHALL load from the array and RVALID SHALL assert the next cycle (1-cycle latency).
- Each R handshake that is not the last SHALL load the next beat's data the same edge, so beats run back-to-back with no bubble while RREADY=1.
REQ-018 Read beat addressing SHALL follow REQ-010 for INCR and FIXED.
REQ-019 For WRAP/reserved types or ARSIZE≠3'b010, the read SHALL return ARLEN+1 beats with RDATA=0 and RRESP=SLVERR; otherwise RRESP=OKAY.
REQ-020 RLAST SHALL be 1 exactly on beat ARLEN; RID SHALL equal the latched ARID.
REQ-021 RDATA, RRESP, RLAST and RID SHALL stay stable while RVALID=1 and RREADY=0.
REQ-022 The read and write FSMs SHALL run independently.
REQ-023 If a write and a read-data load hit the same word in the same cycle, the read SHALL return the pre-write value.
REQ-024 ARLEN up to 255 SHALL be supported; INCR addresses wrap at the 256-byte boundary.

Reset
REQ-025 On ARESETN=0, asynchronously:
- both FSMs SHALL go to IDLE;
- AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST SHALL be 0;
- BRESP, RRESP, BID, RID and RDATA SHALL be 0.
REQ-026 AWREADY and ARREADY SHALL assert on the first S_AXI_ACLK rising edge after ARESETN deasserts.
REQ-027 Array contents SHALL NOT be cleared by reset.
REQ-028 A burst in progress SHALL be abandoned on reset, with no BVALID or RVALID issued for it.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- INCR write: AWADDR=0, AWLEN=7, data 1..8, WSTRB=F -> BRESP=OKAY. INCR read of the same -> 1..8 back-to-back with RREADY=1, RLAST on beat 8.
- Four single-beat writes: AWLEN=0 at 0x0, 0x4, 0x8, 0xC with data 1..4 -> reads return 1..4, RLAST=1 each.
- WSTRB=4'b0011 writing 0xAABBCCDD over 0x11223344 -> read 0x1122CCDD.
- FIXED write: AWLEN=3 at 0x10 with data 5..8 -> read 0x10 returns 8. AWBURST=2'b10 -> BRESP=SLVERR, memory unchanged.
- BREADY low for 10 cycles -> BVALID held, AWREADY stays 0. RREADY toggling -> RDATA stable while stalled.
- ARESETN low mid-burst after beat 3 of 8 -> all VALID/READY outputs 0 immediately; the next AW is accepted.

Source files
------------

// File: rtl/myip_axi4_slave_mem_if.sv
// AXI4 full-protocol bundle for the 256-byte register memory slave.
// Sideband LOCK/CACHE/PROT/QOS/REGION/USER are tied off at the master.
interface myip_axi4_slave_mem_if #(
    parameter int ID_W   = 1,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]     S_AXI_AWID;
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic [7:0]          S_AXI_AWLEN;
    logic [2:0]          S_AXI_AWSIZE;
    logic [1:0]          S_AXI_AWBURST;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;

    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WLAST;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;

    logic [ID_W-1:0]     S_AXI_BID;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;

    logic [ID_W-1:0]     S_AXI_ARID;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic [7:0]          S_AXI_ARLEN;
    logic [2:0]          S_AXI_ARSIZE;
    logic [1:0]          S_AXI_ARBURST;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;

    logic [ID_W-1:0]     S_AXI_RID;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RLAST;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
        output S_AXI_AWBURST, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE,
        output S_AXI_ARBURST, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
        input  S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWID, S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWSIZE,
        input  S_AXI_AWBURST, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BID, S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE,
        input  S_AXI_ARBURST, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
        output S_AXI_RVALID,
        input  S_AXI_RREADY
    );
endinterface

// File: rtl/myip_axi4_slave_mem.sv
// AXI4 burst slave backed by a 64x32 register array.
// Independent write (AW/W/B) and read (AR/R) state machines.
module myip_axi4_slave_mem #(
    parameter int C_S_AXI_ID_WIDTH   = 1,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 8
) (
    input logic S_AXI_ACLK,
    input logic S_AXI_ARESETN,
    myip_axi4_slave_mem_if.slave s_axi
);

    localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
    localparam int ID_W   = C_S_AXI_ID_WIDTH;
    localparam int AW     = C_S_AXI_ADDR_WIDTH;
    localparam int DW     = C_S_AXI_DATA_WIDTH;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_WORD   = 3'b010;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    // Word index is byte address bits [7:2]; upper bits fold away.
    function automatic logic [5:0] word_idx(input logic [AW-1:0] a);
        return 6'(a >> 2);
    endfunction

    function automatic logic [AW-1:0] next_addr(
        input logic [AW-1:0] a,
        input logic [1:0]    burst
    );
        return (burst == BURST_INCR) ? a + AW'(4) : a;
    endfunction

    function automatic logic burst_ok(input logic [1:0] burst);
        return (burst == BURST_INCR) || (burst == BURST_FIXED);
    endfunction

    logic [DW-1:0] mem [64];

    // ---------------- write channel ----------------
    logic [1:0]      w_state;
    logic [AW-1:0]   aw_addr;
    logic [7:0]      aw_len;
    logic [1:0]      aw_burst;
    logic            aw_bad;
    logic [8:0]      w_cnt;
    logic            w_err;
    logic            awready_q;
    logic            wready_q;
    logic            bvalid_q;
    logic [1:0]      bresp_q;
    logic [ID_W-1:0] bid_q;

    logic aw_fire;
    logic w_fire;
    logic w_last_ok;
    logic w_store;

    assign aw_fire   = s_axi.S_AXI_AWVALID && awready_q;
    assign w_fire    = s_axi.S_AXI_WVALID && wready_q;
    assign w_last_ok = s_axi.S_AXI_WLAST == (w_cnt == {1'b0, aw_len});
    assign w_store   = w_fire && burst_ok(aw_burst);

    assign s_axi.S_AXI_AWREADY = awready_q;
    assign s_axi.S_AXI_WREADY  = wready_q;
    assign s_axi.S_AXI_BVALID  = bvalid_q;
    assign s_axi.S_AXI_BRESP   = bresp_q;
    assign s_axi.S_AXI_BID     = bid_q;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            w_state   <= W_IDLE;
            aw_addr   <= '0;
            aw_len    <= '0;
            aw_burst  <= '0;
            aw_bad    <= 1'b0;
            w_cnt     <= '0;
            w_err     <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            bid_q     <= '0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    awready_q <= 1'b1;
                    if (aw_fire) begin
                        bid_q     <= s_axi.S_AXI_AWID;
                        aw_addr   <= s_axi.S_AXI_AWADDR;
                        aw_len    <= s_axi.S_AXI_AWLEN;
                        aw_burst  <= s_axi.S_AXI_AWBURST;
                        aw_bad    <= (s_axi.S_AXI_AWSIZE != SIZE_WORD) ||
                                     !burst_ok(s_axi.S_AXI_AWBURST);
                        w_cnt     <= '0;
                        w_err     <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        w_state   <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_fire) begin
                        aw_addr <= next_addr(aw_addr, aw_burst);
                        w_cnt   <= w_cnt + 9'd1;
                        if (!w_last_ok) begin
                            w_err <= 1'b1;
                        end
                        if (s_axi.S_AXI_WLAST) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (aw_bad || w_err || !w_last_ok) ?
                                        RESP_SLVERR : RESP_OKAY;
                            w_state  <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (s_axi.S_AXI_BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        w_state   <= W_IDLE;
                    end
                end
                default: begin
                    w_state <= W_IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately outside the reset domain so data survives reset.
    always_ff @(posedge S_AXI_ACLK) begin
        if (w_store) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (s_axi.S_AXI_WSTRB[b]) begin
                    mem[word_idx(aw_addr)][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    // ---------------- read channel ----------------
    logic [0:0]      r_state;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_len;
    logic [7:0]      r_cnt;
    logic [1:0]      r_burst;
    logic            r_bad;
    logic            arready_q;
    logic            rvalid_q;
    logic            rlast_q;
    logic [1:0]      rresp_q;
    logic [ID_W-1:0] rid_q;
    logic [DW-1:0]   rdata_q;

    logic ar_fire;
    logic r_fire;
    logic ar_bad;

    assign ar_fire = s_axi.S_AXI_ARVALID && arready_q;
    assign r_fire  = rvalid_q && s_axi.S_AXI_RREADY;
    assign ar_bad  = (s_axi.S_AXI_ARSIZE != SIZE_WORD) ||
                     !burst_ok(s_axi.S_AXI_ARBURST);

    assign s_axi.S_AXI_ARREADY = arready_q;
    assign s_axi.S_AXI_RVALID  = rvalid_q;
    assign s_axi.S_AXI_RLAST   = rlast_q;
    assign s_axi.S_AXI_RRESP   = rresp_q;
    assign s_axi.S_AXI_RID     = rid_q;
    assign s_axi.S_AXI_RDATA   = rdata_q;

    // r_addr always points at the beat to be loaded on the next R handshake.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            r_state   <= R_IDLE;
            r_addr    <= '0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_burst   <= '0;
            r_bad     <= 1'b0;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rid_q     <= '0;
            rdata_q   <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    arready_q <= 1'b1;
                    if (ar_fire) begin
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rid_q     <= s_axi.S_AXI_ARID;
                        r_len     <= s_axi.S_AXI_ARLEN;
                        r_burst   <= s_axi.S_AXI_ARBURST;
                        r_bad     <= ar_bad;
                        r_cnt     <= '0;
                        rresp_q   <= ar_bad ? RESP_SLVERR : RESP_OKAY;
                        rlast_q   <= (s_axi.S_AXI_ARLEN == 8'd0);
                        rdata_q   <= ar_bad ? '0 : mem[word_idx(s_axi.S_AXI_ARADDR)];
                        r_addr    <= next_addr(s_axi.S_AXI_ARADDR, s_axi.S_AXI_ARBURST);
                        r_state   <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_fire) begin
                        if (rlast_q) begin
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                            r_state   <= R_IDLE;
                        end else begin
                            r_cnt   <= r_cnt + 8'd1;
                            rlast_q <= (r_cnt + 8'd1) == r_len;
                            rdata_q <= r_bad ? '0 : mem[word_idx(r_addr)];
                            r_addr  <= next_addr(r_addr, r_burst);
                        end
                    end
                end
                default: begin
                    r_state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_myip_axi4_slave_mem.sv
// Scoreboard bench for myip_axi4_slave_mem.
// Expected read beats come from a byte-lane memory model fed by write stimulus.
module tb_myip_axi4_slave_mem;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_vec = 0;
  int n_err = 0;

  logic [31:0] model [64];
  logic [31:0] wq [$];
  beat_t exp_q [$];
  beat_t got_q [$];

  myip_axi4_slave_mem_if #(.ID_W(1), .ADDR_W(8), .DATA_W(32)) bus ();

  myip_axi4_slave_mem #(
    .C_S_AXI_ID_WIDTH(1),
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(8)
  ) dut (
    .S_AXI_ACLK(clk),
    .S_AXI_ARESETN(rst_n),
    .s_axi(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic bus_idle();
    bus.S_AXI_AWID = '0;
    bus.S_AXI_AWADDR = '0;
    bus.S_AXI_AWLEN = '0;
    bus.S_AXI_AWSIZE = 3'b010;
    bus.S_AXI_AWBURST = 2'b01;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0;
    bus.S_AXI_WSTRB = '0;
    bus.S_AXI_WLAST = 1'b0;
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARID = '0;
    bus.S_AXI_ARADDR = '0;
    bus.S_AXI_ARLEN = '0;
    bus.S_AXI_ARSIZE = 3'b010;
    bus.S_AXI_ARBURST = 2'b01;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic timeout(input string what);
    n_vec++;
    n_err++;
    $display("FAIL timeout_%s: got no handshake expected handshake", what);
  endtask

  task automatic push_exp(input logic [7:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    logic [7:0] a;
    logic bad;
    beat_t e;
    a = addr;
    bad = (size != 3'b010) || (burst > 2'b01);
    for (int i = 0; i <= int'(len); i++) begin
      e.data = bad ? 32'h0 : model[a[7:2]];
      e.resp = bad ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      exp_q.push_back(e);
      if (burst == 2'b01) a = a + 8'd4;
    end
  endtask

  task automatic do_write(input logic id, input logic [7:0] addr,
                          input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] strb,
                          input int bdelay, output logic [1:0] bresp,
                          output logic bid, output logic stall_ok);
    logic [7:0] a;
    int t;
    int n;
    n = wq.size();
    @(negedge clk);
    bus.S_AXI_AWID = id;
    bus.S_AXI_AWADDR = addr;
    bus.S_AXI_AWLEN = len;
    bus.S_AXI_AWSIZE = size;
    bus.S_AXI_AWBURST = burst;
    bus.S_AXI_AWVALID = 1'b1;
    t = 0;
    while (!bus.S_AXI_AWREADY && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout("aw");
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    a = addr;
    for (int i = 0; i < n; i++) begin
      bus.S_AXI_WDATA = wq[i];
      bus.S_AXI_WSTRB = strb;
      bus.S_AXI_WLAST = (i == n - 1);
      bus.S_AXI_WVALID = 1'b1;
      t = 0;
      while (!bus.S_AXI_WREADY && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) timeout("w");
      if (burst <= 2'b01) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[a[7:2]][8*b +: 8] = wq[i][8*b +: 8];
      end
      if (burst == 2'b01) a = a + 8'd4;
      @(negedge clk);
    end
    bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_WLAST = 1'b0;
    wq.delete();
    t = 0;
    while (!bus.S_AXI_BVALID && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout("b");
    bresp = bus.S_AXI_BRESP;
    bid = bus.S_AXI_BID;
    stall_ok = 1'b1;
    for (int k = 0; k < bdelay; k++) begin
      @(negedge clk);
      if (!bus.S_AXI_BVALID || bus.S_AXI_AWREADY || bus.S_AXI_BRESP !== bresp)
        stall_ok = 1'b0;
    end
    bus.S_AXI_BREADY = 1'b1;
    @(negedge clk);
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic id, input logic [7:0] addr,
                         input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic toggle,
                         output int lat, output int span,
                         output logic stable_ok, output logic rid_ok);
    int t;
    int cyc;
    int first;
    int nb;
    logic done;
    logic held_v;
    beat_t hold;
    beat_t cur;
    @(negedge clk);
    bus.S_AXI_ARID = id;
    bus.S_AXI_ARADDR = addr;
    bus.S_AXI_ARLEN = len;
    bus.S_AXI_ARSIZE = size;
    bus.S_AXI_ARBURST = burst;
    bus.S_AXI_ARVALID = 1'b1;
    t = 0;
    while (!bus.S_AXI_ARREADY && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout("ar");
    @(negedge clk);
    bus.S_AXI_ARVALID = 1'b0;
    t = 0;
    while (!bus.S_AXI_RVALID && t < 50) begin @(negedge clk); t++; end
    lat = t;
    cyc = 0; first = -1; nb = 0; done = 1'b0; held_v = 1'b0;
    stable_ok = 1'b1; rid_ok = 1'b1; span = -1;
    while (!done && cyc < 3000) begin
      bus.S_AXI_RREADY = toggle ? (cyc % 2 == 1) : 1'b1;
      cur = {bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_RLAST};
      if (held_v && (!bus.S_AXI_RVALID || cur !== hold)) stable_ok = 1'b0;
      held_v = 1'b0;
      if (bus.S_AXI_RVALID) begin
        if (bus.S_AXI_RREADY) begin
          got_q.push_back(cur);
          nb++;
          if (first < 0) first = cyc;
          if (bus.S_AXI_RID !== id) rid_ok = 1'b0;
          if (bus.S_AXI_RLAST || nb > int'(len)) begin
            done = 1'b1;
            span = cyc - first;
          end
        end else begin
          hold = cur;
          held_v = 1'b1;
        end
      end
      @(negedge clk);
      cyc++;
    end
    bus.S_AXI_RREADY = 1'b0;
    if (!done) timeout("r");
  endtask

  logic [1:0] bresp;
  logic bid;
  logic sok;
  logic stab;
  logic ridok;
  int lat;
  int span;
  beat_t e;
  beat_t g;

  task automatic test_reset();
    bus_idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
         bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_RLAST} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctl: got %b expected 000000",
               {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_RLAST});
    end
    n_vec++;
    if ({bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_BID, bus.S_AXI_RID} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_resp: got %b expected 000000",
               {bus.S_AXI_BRESP, bus.S_AXI_RRESP, bus.S_AXI_BID, bus.S_AXI_RID});
    end
    n_vec++;
    if (bus.S_AXI_RDATA !== 32'h0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h expected 00000000", bus.S_AXI_RDATA);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_ARREADY} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_release: got %b expected 11",
               {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY});
    end
  endtask

  task automatic check_bresp(input string name, input logic [1:0] want,
                             input logic want_id);
    n_vec++;
    if (bresp !== want || bid !== want_id) begin
      n_err++;
      $display("FAIL %s: got bresp=%b bid=%b expected bresp=%b bid=%b",
               name, bresp, bid, want, want_id);
    end
  endtask

  task automatic test_fill_long();
    for (int i = 0; i < 64; i++) wq.push_back(32'h5A00_0000 | 32'(i * 3));
    do_write(1'b0, 8'h00, 8'd63, 3'b010, 2'b01, 4'hF, 0, bresp, bid, sok);
    check_bresp("fill_bresp", 2'b00, 1'b0);
    push_exp(8'h00, 8'd255, 3'b010, 2'b01);
    do_read(1'b0, 8'h00, 8'd255, 3'b010, 2'b01, 1'b0, lat, span, stab, ridok);
    n_vec++;
    if (span !== 255 || !ridok) begin
      n_err++;
      $display("FAIL long_span: got span=%0d rid_ok=%b expected 255 1", span, ridok);
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL long_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL long_beat: got %h/%b/%b expected %h/%b/%b",
                 g.data, g.resp, g.last, e.data, e.resp, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_incr();
    for (int i = 1; i <= 8; i++) wq.push_back(32'(i));
    do_write(1'b1, 8'h00, 8'd7, 3'b010, 2'b01, 4'hF, 0, bresp, bid, sok);
    check_bresp("incr_bresp", 2'b00, 1'b1);
    push_exp(8'h00, 8'd7, 3'b010, 2'b01);
    do_read(1'b1, 8'h00, 8'd7, 3'b010, 2'b01, 1'b0, lat, span, stab, ridok);
    n_vec++;
    if (lat !== 0 || span !== 7 || !ridok) begin
      n_err++;
      $display("FAIL incr_timing: got lat=%0d span=%0d rid_ok=%b expected 0 7 1",
               lat, span, ridok);
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL incr_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL incr_beat: got %h/%b/%b expected %h/%b/%b",
                 g.data, g.resp, g.last, e.data, e.resp, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_single();
    for (int k = 0; k < 4; k++) begin
      wq.push_back(32'(k + 1));
      do_write(1'b0, 8'(4 * k), 8'd0, 3'b010, 2'b01, 4'hF, 0, bresp, bid, sok);
      check_bresp("single_bresp", 2'b00, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      push_exp(8'(4 * k), 8'd0, 3'b010, 2'b01);
      do_read(1'b0, 8'(4 * k), 8'd0, 3'b010, 2'b01, 1'b0, lat, span, stab, ridok);
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL single_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL single_beat: got %h/%b/%b expected %h/%b/%b",
                 g.data, g.resp, g.last, e.data, e.resp, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_strb();
    wq.push_back(32'h1122_3344);
    do_write(1'b0, 8'h20, 8'd0, 3'b010, 2'b01, 4'hF, 0, bresp, bid, sok);
    wq.push_back(32'hAABB_CCDD);
    do_write(1'b0, 8'h20, 8'd0, 3'b010, 2'b01, 4'b0011, 0, bresp, bid, sok);
    check_bresp("strb_bresp", 2'b00, 1'b0);
    do_read(1'b0, 8'h20, 8'd0, 3'b010, 2'b01, 1'b0, lat, span, stab, ridok);
    n_vec++;
    if (got_q.size() != 1 || got_q[0].data !== 32'h1122_CCDD) begin
      n_err++;
      $display("FAIL strb_data: got %h expected 1122ccdd",
               got_q.size() > 0 ? got_q[0].data : 32'hx);
    end
    got_q.delete();
  endtask

  task automatic test_fixed_wrap();
    for (int i = 5; i <= 8; i++) wq.push_back(32'(i));
    do_write(1'b1, 8'h10, 8'd3, 3'b010, 2'b00, 4'hF, 0, bresp, bid, sok);
    check_bresp("fixed_bresp", 2'b00, 1'b1);
    wq.push_back(32'hDEAD_0001);
    wq.push_back(32'hDEAD_0002);
    do_write(1'b0, 8'h10, 8'd1, 3'b010, 2'b10, 4'hF, 0, bresp, bid, sok);
    check_bresp("wrap_bresp", 2'b10, 1'b0);
    push_exp(8'h10, 8'd0, 3'b010, 2'b01);
    do_read(1'b0, 8'h10, 8'd0, 3'b010, 2'b01, 1'b0, lat, span, stab, ridok);
    push_exp(8'h14, 8'd0, 3'b010, 2'b01);
    do_read(1'b0, 8'h14, 8'd0, 3'b010, 2'b01, 1'b0, lat, span, stab, ridok);
    push_exp(8'h10, 8'd2, 3'b010, 2'b00);
    do_read(1'b1, 8'h10, 8'd2, 3'b010, 2'b00, 1'b0, lat, span, stab, ridok);
    push_exp(8'h10, 8'd1, 3'b010, 2'b10);
    do_read(1'b0, 8'h10, 8'd1, 3'b010, 2'b10, 1'b0, lat, span, stab, ridok);
    n_vec++;
    if (got_q.size() != exp_q.size() || got_q[0].data !== 32'd8) begin
      n_err++;
      $display("FAIL fixed_count: got %0d beats expected %0d with first 8",
               got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL fixed_beat: got %h/%b/%b expected %h/%b/%b",
                 g.data, g.resp, g.last, e.data, e.resp, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_errors();
    wq.push_back(32'h0000_0077);
    do_write(1'b0, 8'h80, 8'd0, 3'b001, 2'b01, 4'hF, 0, bresp, bid, sok);
    check_bresp("size_bresp", 2'b10, 1'b0);
    wq.push_back(32'h0000_0091);
    wq.push_back(32'h0000_0092);
    do_write(1'b1, 8'h90, 8'd3, 3'b010, 2'b01, 4'hF, 0, bresp, bid, sok);
    check_bresp("early_last", 2'b10, 1'b1);
    wq.push_back(32'h0000_00A1);
    wq.push_back(32'h0000_00A2);
    do_write(1'b0, 8'hA0, 8'd0, 3'b010, 2'b01, 4'hF, 0, bresp, bid, sok);
    check_bresp("late_last", 2'b10, 1'b0);
    wq.push_back(32'h0000_00B1);
    do_write(1'b1, 8'hB0, 8'd0, 3'b010, 2'b01, 4'hF, 0, bresp, bid, sok);
    check_bresp("recover", 2'b00, 1'b1);
    push_exp(8'h80, 8'd1, 3'b001, 2'b01);
    do_read(1'b0, 8'h80, 8'd1, 3'b001, 2'b01, 1'b0, lat, span, stab, ridok);
    push_exp(8'h90, 8'd1, 3'b010, 2'b01);
    do_read(1'b0, 8'h90, 8'd1, 3'b010, 2'b01, 1'b0, lat, span, stab, ridok);
    push_exp(8'hA0, 8'd1, 3'b010, 2'b01);
    do_read(1'b0, 8'hA0, 8'd1, 3'b010, 2'b01, 1'b0, lat, span, stab, ridok);
    push_exp(8'hB0, 8'd0, 3'b010, 2'b11);
    do_read(1'b0, 8'hB0, 8'd0, 3'b010, 2'b11, 1'b0, lat, span, stab, ridok);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL err_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL err_beat: got %h/%b/%b expected %h/%b/%b",
                 g.data, g.resp, g.last, e.data, e.resp, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 4; i++) wq.push_back(32'hC0 + 32'(i));
    do_write(1'b0, 8'hF8, 8'd3, 3'b010, 2'b01, 4'hF, 0, bresp, bid, sok);
    check_bresp("bound_bresp", 2'b00, 1'b0);
    push_exp(8'hF8, 8'd3, 3'b010, 2'b01);
    do_read(1'b0, 8'hF8, 8'd3, 3'b010, 2'b01, 1'b0, lat, span, stab, ridok);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL bound_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL bound_beat: got %h/%b/%b expected %h/%b/%b",
                 g.data, g.resp, g.last, e.data, e.resp, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_back_to_back_stall();
    wq.push_back(32'h51);
    wq.push_back(32'h52);
    do_write(1'b1, 8'h60, 8'd1, 3'b010, 2'b01, 4'hF, 10, bresp, bid, sok);
    n_vec++;
    if (!sok) begin
      n_err++;
      $display("FAIL bstall: got held=0 expected held=1");
    end
    check_bresp("bstall_bresp", 2'b00, 1'b1);
    push_exp(8'h00, 8'd7, 3'b010, 2'b01);
    do_read(1'b1, 8'h00, 8'd7, 3'b010, 2'b01, 1'b1, lat, span, stab, ridok);
    n_vec++;
    if (!stab || !ridok) begin
      n_err++;
      $display("FAIL rstall: got stable=%b rid_ok=%b expected 1 1", stab, ridok);
    end
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL rstall_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL rstall_beat: got %h/%b/%b expected %h/%b/%b",
                 g.data, g.resp, g.last, e.data, e.resp, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    int t;
    logic bad_b;
    @(negedge clk);
    bus.S_AXI_AWID = 1'b1;
    bus.S_AXI_AWADDR = 8'h40;
    bus.S_AXI_AWLEN = 8'd7;
    bus.S_AXI_AWSIZE = 3'b010;
    bus.S_AXI_AWBURST = 2'b01;
    bus.S_AXI_AWVALID = 1'b1;
    t = 0;
    while (!bus.S_AXI_AWREADY && t < 200) begin @(negedge clk); t++; end
    if (t >= 200) timeout("aw_mid");
    @(negedge clk);
    bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.S_AXI_WDATA = 32'hA0 + 32'(i);
      bus.S_AXI_WSTRB = 4'hF;
      bus.S_AXI_WLAST = 1'b0;
      bus.S_AXI_WVALID = 1'b1;
      t = 0;
      while (!bus.S_AXI_WREADY && t < 200) begin @(negedge clk); t++; end
      if (t >= 200) timeout("w_mid");
      model[16 + i] = 32'hA0 + 32'(i);
      @(negedge clk);
    end
    bus.S_AXI_WVALID = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
         bus.S_AXI_ARREADY, bus.S_AXI_RVALID} !== 5'b0) begin
      n_err++;
      $display("FAIL mid_reset: got %b expected 00000",
               {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID,
                bus.S_AXI_ARREADY, bus.S_AXI_RVALID});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad_b = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.S_AXI_BVALID || bus.S_AXI_RVALID || !bus.S_AXI_AWREADY) bad_b = 1'b1;
    end
    n_vec++;
    if (bad_b) begin
      n_err++;
      $display("FAIL mid_after: got stray valid or no awready expected idle");
    end
    wq.push_back(32'hE0);
    do_write(1'b0, 8'hC0, 8'd0, 3'b010, 2'b01, 4'hF, 0, bresp, bid, sok);
    check_bresp("mid_next_aw", 2'b00, 1'b0);
    push_exp(8'h40, 8'd2, 3'b010, 2'b01);
    do_read(1'b0, 8'h40, 8'd2, 3'b010, 2'b01, 1'b0, lat, span, stab, ridok);
    push_exp(8'h08, 8'd0, 3'b010, 2'b01);
    do_read(1'b0, 8'h08, 8'd0, 3'b010, 2'b01, 1'b0, lat, span, stab, ridok);
    n_vec++;
    if (got_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL mid_count: got %0d expected %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL mid_beat: got %h/%b/%b expected %h/%b/%b",
                 g.data, g.resp, g.last, e.data, e.resp, e.last);
      end
    end
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    test_reset();
    test_fill_long();
    test_incr();
    test_single();
    test_strb();
    test_fixed_wrap();
    test_errors();
    test_boundary();
    test_back_to_back_stall();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
